// File: rtl/acq_pkg.sv
// -----------------------------------------------------------------------------
// acq_pkg
// Shared constants and types for the acquisition delay-buffer controller.
//   DEPTH   : ring-buffer depth in samples
//   AW      : RAM address width
//   DW      : sample width
//   state_t : controller state (CLEAR sweep, RUN service)
// -----------------------------------------------------------------------------
package acq_pkg;

    localparam int DEPTH = 512;
    localparam int AW    = 9;
    localparam int DW    = 16;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

endpackage : acq_pkg

// File: rtl/delay_buf_ctrl.sv
// -----------------------------------------------------------------------------
// delay_buf_ctrl
// Controller for a microphone-sample delay line held in an external
// simple-dual-port RAM. After reset the whole RAM is swept to zero, then
// incoming samples are written round-robin while read requests fetch the
// sample that lies 'req_delay' writes in the past.
//
// Ports
//   clk, rst_n             : clock (rising edge), async active-low reset
//   smp_valid/smp_data     : new-sample strobe and signed sample
//   req_valid/req_ready    : delayed-read request handshake
//   req_delay              : requested delay (0 = newest stored sample)
//   rsp_valid/rsp_data     : response strobe and delayed sample
//   rsp_under              : delay beyond stored history, data forced to 0
//   busy_clr               : clear sweep in progress
//   drop_flag              : sticky, a sample arrived during the sweep
//   ram_cea/ram_ada/ram_din: RAM write port
//   ram_ceb/ram_adb        : RAM read port
//   ram_oce                : RAM output-register enable (tied high)
//   ram_dout               : RAM read data, one cycle after the ceb edge
// -----------------------------------------------------------------------------
module delay_buf_ctrl #(
    parameter int DEPTH = 512,
    parameter int AW    = 9,
    parameter int DW    = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          smp_valid,
    input  logic [DW-1:0] smp_data,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [AW-1:0] req_delay,
    output logic          rsp_valid,
    output logic [DW-1:0] rsp_data,
    output logic          rsp_under,
    output logic          busy_clr,
    output logic          drop_flag,
    output logic          ram_cea,
    output logic [AW-1:0] ram_ada,
    output logic [DW-1:0] ram_din,
    output logic          ram_ceb,
    output logic [AW-1:0] ram_adb,
    output logic          ram_oce,
    input  logic [DW-1:0] ram_dout
);

    import acq_pkg::*;

    // fill counts 0..DEPTH, so it needs one more bit than an address
    localparam int             FW       = $clog2(DEPTH + 1);
    localparam int             AWE      = AW + 1;
    localparam logic [FW-1:0]  DEPTH_F  = FW'(DEPTH);
    localparam logic [FW-1:0]  FILL_ONE = FW'(1);
    localparam logic [AW-1:0]  ADDR_ONE = AW'(1);
    localparam logic [AW-1:0]  WP_LAST  = AW'(DEPTH - 1);
    // largest delay that can never alias the address being written
    localparam logic [AW-1:0]  DMAX     = AW'(DEPTH - 2);
    localparam logic [AWE-1:0] DEPTH_E  = AWE'(DEPTH);
    localparam logic [AWE-1:0] DEPTH_M1 = AWE'(DEPTH - 1);

    state_t         state_r,     state_s;
    logic [FW-1:0]  clr_cnt_r,   clr_cnt_s;
    logic [AW-1:0]  wr_ptr_r,    wr_ptr_s;
    logic [FW-1:0]  fill_r,      fill_s;
    logic           req_ready_r, req_ready_s;
    logic           busy_clr_r,  busy_clr_s;
    logic           drop_flag_r, drop_flag_s;
    logic           ram_cea_r,   ram_cea_s;
    logic [AW-1:0]  ram_ada_r,   ram_ada_s;
    logic [DW-1:0]  ram_din_r,   ram_din_s;
    logic           ram_ceb_r,   ram_ceb_s;
    logic [AW-1:0]  ram_adb_r,   ram_adb_s;
    logic           s1_valid_r,  s1_valid_s;
    logic           s1_under_r,  s1_under_s;
    logic           s2_valid_r;
    logic           s2_under_r;
    logic           rsp_valid_r;
    logic [DW-1:0]  rsp_data_r;
    logic           rsp_under_r;

    logic           req_accept_s;
    logic [AW-1:0]  d_s;
    logic [AWE-1:0] sum_s;
    logic [AW-1:0]  rd_addr_s;
    logic           under_s;

    // Read-address arithmetic: clamp the delay, then step back from the
    // pre-increment write pointer so a same-cycle write is never seen.
    always_comb begin
        req_accept_s = req_valid & req_ready_r & (state_r == RUN);
        if (req_delay > DMAX) begin
            d_s = DMAX;
        end else begin
            d_s = req_delay;
        end
        // wr_ptr + DEPTH - 1 - d stays in [1, 2*DEPTH-2], one conditional
        // subtract brings it back into range
        sum_s = {1'b0, wr_ptr_r} + DEPTH_M1 - {1'b0, d_s};
        if (sum_s >= DEPTH_E) begin
            rd_addr_s = sum_s[AW-1:0] - DEPTH_E[AW-1:0];
        end else begin
            rd_addr_s = sum_s[AW-1:0];
        end
        under_s = (FW'(d_s) >= fill_r);
    end

    // Next-state and next-output logic for the CLEAR/RUN controller.
    always_comb begin
        state_s     = state_r;
        clr_cnt_s   = clr_cnt_r;
        wr_ptr_s    = wr_ptr_r;
        fill_s      = fill_r;
        req_ready_s = req_ready_r;
        busy_clr_s  = busy_clr_r;
        drop_flag_s = drop_flag_r;
        ram_cea_s   = 1'b0;
        ram_ada_s   = ram_ada_r;
        ram_din_s   = ram_din_r;
        ram_ceb_s   = 1'b0;
        ram_adb_s   = ram_adb_r;
        s1_valid_s  = 1'b0;
        s1_under_s  = 1'b0;

        case (state_r)
            CLEAR: begin
                req_ready_s = 1'b0;
                busy_clr_s  = 1'b1;
                wr_ptr_s    = {AW{1'b0}};
                fill_s      = {FW{1'b0}};
                // samples cannot be stored during the sweep
                if (smp_valid) begin
                    drop_flag_s = 1'b1;
                end else begin
                    drop_flag_s = drop_flag_r;
                end
                if (clr_cnt_r < DEPTH_F) begin
                    ram_cea_s = 1'b1;
                    ram_ada_s = clr_cnt_r[AW-1:0];
                    ram_din_s = {DW{1'b0}};
                    clr_cnt_s = clr_cnt_r + FILL_ONE;
                end else begin
                    // last zero write has reached the RAM; start service
                    state_s     = RUN;
                    clr_cnt_s   = {FW{1'b0}};
                    req_ready_s = 1'b1;
                    busy_clr_s  = 1'b0;
                end
            end
            RUN: begin
                req_ready_s = 1'b1;
                busy_clr_s  = 1'b0;
                if (smp_valid) begin
                    ram_cea_s = 1'b1;
                    ram_ada_s = wr_ptr_r;
                    ram_din_s = smp_data;
                    if (wr_ptr_r == WP_LAST) begin
                        wr_ptr_s = {AW{1'b0}};
                    end else begin
                        wr_ptr_s = wr_ptr_r + ADDR_ONE;
                    end
                    if (fill_r == DEPTH_F) begin
                        fill_s = fill_r;
                    end else begin
                        fill_s = fill_r + FILL_ONE;
                    end
                end else begin
                    ram_cea_s = 1'b0;
                end
                // the RAM read is issued even for an underflow so the
                // response pipeline keeps a fixed latency
                if (req_accept_s) begin
                    ram_ceb_s  = 1'b1;
                    ram_adb_s  = rd_addr_s;
                    s1_valid_s = 1'b1;
                    s1_under_s = under_s;
                end else begin
                    ram_ceb_s  = 1'b0;
                end
            end
            default: begin
                state_s     = CLEAR;
                clr_cnt_s   = {FW{1'b0}};
                req_ready_s = 1'b0;
                busy_clr_s  = 1'b1;
            end
        endcase
    end

    // Controller state and registered RAM/handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= CLEAR;
            clr_cnt_r   <= {FW{1'b0}};
            wr_ptr_r    <= {AW{1'b0}};
            fill_r      <= {FW{1'b0}};
            req_ready_r <= 1'b0;
            busy_clr_r  <= 1'b1;
            drop_flag_r <= 1'b0;
            ram_cea_r   <= 1'b0;
            ram_ada_r   <= {AW{1'b0}};
            ram_din_r   <= {DW{1'b0}};
            ram_ceb_r   <= 1'b0;
            ram_adb_r   <= {AW{1'b0}};
            s1_valid_r  <= 1'b0;
            s1_under_r  <= 1'b0;
        end else begin
            state_r     <= state_s;
            clr_cnt_r   <= clr_cnt_s;
            wr_ptr_r    <= wr_ptr_s;
            fill_r      <= fill_s;
            req_ready_r <= req_ready_s;
            busy_clr_r  <= busy_clr_s;
            drop_flag_r <= drop_flag_s;
            ram_cea_r   <= ram_cea_s;
            ram_ada_r   <= ram_ada_s;
            ram_din_r   <= ram_din_s;
            ram_ceb_r   <= ram_ceb_s;
            ram_adb_r   <= ram_adb_s;
            s1_valid_r  <= s1_valid_s;
            s1_under_r  <= s1_under_s;
        end
    end

    // Response pipeline: stage 2 waits for the RAM read, then the result
    // is captured from ram_dout (or forced to zero on underflow).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_r  <= 1'b0;
            s2_under_r  <= 1'b0;
            rsp_valid_r <= 1'b0;
            rsp_data_r  <= {DW{1'b0}};
            rsp_under_r <= 1'b0;
        end else begin
            s2_valid_r  <= s1_valid_r;
            s2_under_r  <= s1_under_r;
            rsp_valid_r <= s2_valid_r;
            if (s2_valid_r) begin
                rsp_under_r <= s2_under_r;
                if (s2_under_r) begin
                    rsp_data_r <= {DW{1'b0}};
                end else begin
                    rsp_data_r <= ram_dout;
                end
            end else begin
                rsp_under_r <= 1'b0;
                rsp_data_r  <= rsp_data_r;
            end
        end
    end

    assign req_ready = req_ready_r;
    assign busy_clr  = busy_clr_r;
    assign drop_flag = drop_flag_r;
    assign ram_cea   = ram_cea_r;
    assign ram_ada   = ram_ada_r;
    assign ram_din   = ram_din_r;
    assign ram_ceb   = ram_ceb_r;
    assign ram_adb   = ram_adb_r;
    assign ram_oce   = 1'b1;
    assign rsp_valid = rsp_valid_r;
    assign rsp_data  = rsp_data_r;
    assign rsp_under = rsp_under_r;

endmodule : delay_buf_ctrl
